// File: rtl/cmerge_pkg.sv
// Shared definitions for the clocked merge controllers: FSM encodings,
// default sizing constants and a constant-foldable ceil(log2) helper.
package cmerge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RECOVER = 2'd2
    } state_e;

    localparam int DEF_N       = 5;
    localparam int DEF_W       = 5;
    localparam int DEF_TIMEOUT = 255;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/merge_rr_arbiter_chk.sv
// Protocol checker for merge_rr_arbiter: request held while granted,
// one-hot free, and free never overlapping a downstream drive.
module merge_rr_arbiter_chk #(
    parameter int N  = 5,
    parameter int IW = 3
) (
    input logic          clk,
    input logic          rst,
    input logic [N-1:0]  i_drive,
    input logic [N-1:0]  o_free,
    input logic          o_driveNext,
    input logic [IW-1:0] o_grant_idx
);

    a_hold_while_granted: assert property (@(posedge clk) disable iff (rst)
        o_driveNext |-> i_drive[o_grant_idx])
        else $error("granted requester dropped its request");

    a_free_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(o_free))
        else $error("more than one free bit high");

    a_free_vs_drive: assert property (@(posedge clk) disable iff (rst)
        !((|o_free) && o_driveNext))
        else $error("free and driveNext high together");

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr_i,
// wrapping from N-1 back to 0.
module rr_pick #(
    parameter int N  = 5,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    // Scan N candidates starting at the pointer; the first hit wins.
    always_comb begin
        logic [IW-1:0] cand;
        logic          hit;
        valid_o = 1'b0;
        idx_o   = {IW{1'b0}};
        for (int i = 0; i < N; i++) begin
            cand    = IW'((int'(ptr_i) + i) % N);
            hit     = req_i[cand] && !valid_o;
            idx_o   = hit ? cand : idx_o;
            valid_o = valid_o | req_i[cand];
        end
    end

endmodule

// File: rtl/merge_rr_arbiter.sv
// N-way round-robin merge arbiter onto one drive/free downstream channel.
// Optional grant watchdog enabled by defining MERGE_ARB_TIMEOUT_EN.
module merge_rr_arbiter
    import cmerge_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
`ifdef MERGE_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = DEF_TIMEOUT
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          i_drive,
    input  logic [N*W-1:0]        i_data,
    output logic [N-1:0]          o_free,
    output logic                  o_driveNext,
    output logic [W-1:0]          o_data,
    input  logic                  i_freeNext,
`ifdef MERGE_ARB_TIMEOUT_EN
    output logic                  o_timeout,
`endif
    output logic [clog2(N)-1:0]   o_grant_idx
);

    localparam int IW = clog2(N);

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [W-1:0]    data_q, data_d;
    logic            drive_q, drive_d;
    logic [N-1:0]    free_q, free_d;
    logic            pick_valid_s;
    logic [IW-1:0]   pick_idx_s;
    logic [W-1:0]    data_arr_s [N];
    logic            expire_s;

`ifdef MERGE_ARB_TIMEOUT_EN
    localparam int CW = clog2(TIMEOUT + 1);
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            timeout_q, timeout_d;

    assign expire_s  = (cnt_q == CW'(TIMEOUT - 1));
    assign o_timeout = timeout_q;
`else
    assign expire_s  = 1'b0;
`endif

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req_i   (i_drive),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid_s),
        .idx_o   (pick_idx_s)
    );

    // Unpack the flat payload bus into one slice per requester.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            data_arr_s[k] = i_data[k*W +: W];
        end
    end

    // Next-state and next-output logic of the grant FSM.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        data_d    = data_q;
        drive_d   = drive_q;
        free_d    = {N{1'b0}};
`ifdef MERGE_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    grant_d = pick_idx_s;
                    data_d  = data_arr_s[pick_idx_s];
                    drive_d = 1'b1;
                    state_d = ST_BUSY;
`ifdef MERGE_ARB_TIMEOUT_EN
                    cnt_d   = {CW{1'b0}};
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // A real free beats a simultaneous watchdog expiry.
                if (i_freeNext || expire_s) begin
                    free_d  = {{(N-1){1'b0}}, 1'b1} << grant_q;
                    drive_d = 1'b0;
                    data_d  = {W{1'b0}};
                    ptr_d   = (grant_q == IW'(N - 1)) ? {IW{1'b0}} : grant_q + IW'(1);
                    state_d = ST_RECOVER;
`ifdef MERGE_ARB_TIMEOUT_EN
                    timeout_d = !i_freeNext;
`endif
                end else begin
`ifdef MERGE_ARB_TIMEOUT_EN
                    cnt_d   = cnt_q + CW'(1);
`endif
                    state_d = ST_BUSY;
                end
            end
            ST_RECOVER: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                drive_d = 1'b0;
                data_d  = {W{1'b0}};
            end
        endcase
    end

    // State and registered outputs; reset drops any grant immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= {IW{1'b0}};
            grant_q   <= {IW{1'b0}};
            data_q    <= {W{1'b0}};
            drive_q   <= 1'b0;
            free_q    <= {N{1'b0}};
`ifdef MERGE_ARB_TIMEOUT_EN
            cnt_q     <= {CW{1'b0}};
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            data_q    <= data_d;
            drive_q   <= drive_d;
            free_q    <= free_d;
`ifdef MERGE_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign o_free      = free_q;
    assign o_driveNext = drive_q;
    assign o_data      = data_q;
    assign o_grant_idx = grant_q;

endmodule

// File: tb/tb_merge_rr_arbiter.sv
// Directed self-checking bench for merge_rr_arbiter (N=5, W=5).
module tb_merge_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  i_drive;
    logic [24:0] i_data;
    logic [4:0]  o_free;
    logic        o_driveNext;
    logic [4:0]  o_data;
    logic        i_freeNext;
    logic [2:0]  o_grant_idx;
`ifdef MERGE_ARB_TIMEOUT_EN
    logic        o_timeout;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [4:0] dv [5] = '{5'h07, 5'h03, 5'h15, 5'h0A, 5'h1F};

    always #5 clk = ~clk;

    merge_rr_arbiter #(
        .N(5),
        .W(5)
`ifdef MERGE_ARB_TIMEOUT_EN
        ,
        .TIMEOUT(8)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_drive     (i_drive),
        .i_data      (i_data),
        .o_free      (o_free),
        .o_driveNext (o_driveNext),
        .o_data      (o_data),
        .i_freeNext  (i_freeNext),
`ifdef MERGE_ARB_TIMEOUT_EN
        .o_timeout   (o_timeout),
`endif
        .o_grant_idx (o_grant_idx)
    );

    merge_rr_arbiter_chk #(.N(5), .IW(3)) u_chk (
        .clk         (clk),
        .rst         (rst),
        .i_drive     (i_drive),
        .o_free      (o_free),
        .o_driveNext (o_driveNext),
        .o_grant_idx (o_grant_idx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full grant: wait for the rise, free it two cycles later, check the pulse.
    task automatic serve(input string tag, input int exp_idx, input logic [4:0] exp_data,
                         input logic [4:0] release_mask);
        int n;
        n = 0;
        while (!o_driveNext && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_wait"}, n, 1);
        check({tag, "_idx"}, o_grant_idx, exp_idx);
        check({tag, "_data"}, o_data, exp_data);
        tick();
        tick();
        i_freeNext = 1'b1;
        tick();
        i_freeNext = 1'b0;
        check({tag, "_free"}, o_free, 5'b00001 << exp_idx);
        check({tag, "_free_drive"}, o_driveNext, 0);
        check({tag, "_free_data"}, o_data, 0);
        i_drive = i_drive & ~release_mask;
        tick();
        check({tag, "_free_once"}, o_free, 0);
        check({tag, "_recover_idle"}, o_driveNext, 0);
    endtask

    initial begin
        rst        = 1'b1;
        i_drive    = 5'b00000;
        i_freeNext = 1'b0;
        i_data     = {dv[4], dv[3], dv[2], dv[1], dv[0]};
        tick();
        tick();
        check("rst_free", o_free, 0);
        check("rst_drive", o_driveNext, 0);
        check("rst_data", o_data, 0);
        check("rst_idx", o_grant_idx, 0);
`ifdef MERGE_ARB_TIMEOUT_EN
        check("rst_timeout", o_timeout, 0);
`endif
        rst = 1'b0;
        tick();

        // Single request from requester 2; pointer moves to 3.
        i_drive = 5'b00100;
        check("single_pre", o_driveNext, 0);
        serve("single", 2, 5'h15, 5'b00100);

        // Stray free in IDLE is ignored.
        i_freeNext = 1'b1;
        tick();
        i_freeNext = 1'b0;
        check("stray_free", o_free, 0);
        check("stray_drive", o_driveNext, 0);

        // Serve 3 so the pointer sits at 4, then 4 wins over 0 and wraps.
        i_drive = 5'b01000;
        serve("p3", 3, 5'h0A, 5'b01000);
        i_drive = 5'b10001;
        serve("wrap4", 4, 5'h1F, 5'b10000);
        serve("wrap0", 0, 5'h07, 5'b00001);

        // Requester 1 holds through RECOVER and is granted again afterwards.
        i_drive = 5'b00010;
        serve("hold1", 1, 5'h03, 5'b00000);
        serve("regrant1", 1, 5'h03, 5'b00010);

        // Asynchronous reset in the middle of a grant (pointer was 2).
        i_drive = 5'b00100;
        tick();
        check("midrst_busy", o_driveNext, 1);
        #3;
        rst     = 1'b1;
        i_drive = 5'b00000;
        #1;
        check("midrst_drive", o_driveNext, 0);
        check("midrst_data", o_data, 0);
        check("midrst_free", o_free, 0);
        check("midrst_idx", o_grant_idx, 0);
        #1;
        rst = 1'b0;
        tick();
        check("postrst_nofree", o_free, 0);
        i_drive = 5'b00110;
        serve("postrst", 1, 5'h03, 5'b00010);
        serve("postrst2", 2, 5'h15, 5'b00100);

        // All five requesting from a fresh pointer: 0,1,2,3,4,0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        i_drive = 5'b11111;
        for (int k = 0; k < 6; k++) begin
            serve($sformatf("rr%0d", k), k % 5, dv[k % 5], 5'b00000);
        end
        i_drive = 5'b00000;
        tick();
        tick();
        check("rr_done_idle", o_driveNext, 0);

`ifdef MERGE_ARB_TIMEOUT_EN
        // Watchdog abort 8 cycles after the grant (pointer is 1, so 3 wins).
        i_drive = 5'b01000;
        tick();
        check("to_rise", o_driveNext, 1);
        for (int k = 0; k < 7; k++) tick();
        check("to_before", o_timeout, 0);
        check("to_before_drive", o_driveNext, 1);
        tick();
        check("to_pulse", o_timeout, 1);
        check("to_free", o_free, 5'b01000);
        check("to_drive", o_driveNext, 0);
        i_drive = 5'b00000;
        tick();
        check("to_once", o_timeout, 0);
        check("to_free_once", o_free, 0);
        tick();

        // Free arriving on the expiry cycle completes normally.
        i_drive = 5'b00100;
        tick();
        check("tf_rise", o_driveNext, 1);
        for (int k = 0; k < 7; k++) tick();
        i_freeNext = 1'b1;
        tick();
        i_freeNext = 1'b0;
        check("tf_free", o_free, 5'b00100);
        check("tf_timeout", o_timeout, 0);
        i_drive = 5'b00000;
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/merge_rr_arbiter.md
Name: merge_rr_arbiter

Overview:
- Synchronous N-way merge arbiter. It shares one downstream drive/free channel (5-bit payload) between N requesters using round-robin fairness.
- Clocked counterpart of the mutex-merge control stage, used in the cache replacement control path where requesters live in the clocked domain.
- Latches the winner's data, holds the grant until downstream frees the channel, then returns a free pulse to the winner.

Parameters:
- N, 5, number of requesters (2..8)
- W, 5, payload width per requester
- TIMEOUT, 255, grant watchdog limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- i_drive  in  N  per-requester level request; held high until its o_free pulse is seen
- i_data  in  N*W  packed payloads; requester k owns bits [k*W +: W]; stable while i_drive[k] is high
- o_free  out  N  one-cycle registered acknowledge to the granted requester
- o_driveNext  out  1  level request to downstream; high while a grant is outstanding
- o_data  out  W  registered payload of the granted requester; 0 when no grant
- i_freeNext  in  1  one-cycle pulse from downstream: transfer consumed
- o_grant_idx  out  clog2(N)  index of current or last winner (debug/observation)

Interface decision: one clock (clk); reset rst is asynchronous and active-high.

Behaviour:
- Reset values: state IDLE; o_free=0; o_driveNext=0; o_data=0; o_grant_idx=0; rr pointer=0.
- FSM states:
  - IDLE:
    - If i_drive has no bits set, stay in IDLE.
    - Otherwise pick the first set bit scanning from the rr pointer upward, wrapping N-1 -> 0.
    - Latch the winner's index into o_grant_idx and its i_data slice into o_data.
    - Set o_driveNext=1 and go to BUSY.
    - Latency: request sampled in cycle t gives o_driveNext=1 at t+1.
  - BUSY:
    - Hold o_driveNext, o_data and o_grant_idx.
    - On i_freeNext=1: o_free[grant]=1 for exactly the next cycle, o_driveNext=0, o_data=0, pointer=(grant+1) mod N, go to RECOVER.
  - RECOVER (one cycle):
    - o_free pulse is visible; i_drive is ignored, so the winner can drop its request.
    - Next state IDLE.
    - Minimum back-to-back grant spacing: 3 cycles from one o_driveNext rise to the next.
- Fairness: the requester just served has lowest priority next round. With all N requesting, grants rotate 0,1,...,N-1,0.
- i_freeNext in IDLE or RECOVER is ignored; no o_free is generated.
- i_drive[k] dropping while k is granted is illegal. The grant completes normally regardless; assertion flags it in simulation.
- A requester that holds i_drive after its o_free is treated as a new request in the next IDLE.
- Simultaneous i_freeNext and new requests: the new requests are arbitrated only after RECOVER, never in the same cycle.
- At most one o_free bit is high in any cycle. o_free and o_driveNext are never both high.
- rst mid-BUSY: the grant is dropped immediately and asynchronously, all outputs return to reset values, and no o_free is issued.

Optional Feature:
- Macro MERGE_ARB_TIMEOUT_EN.
- With the macro:
  - Adds output o_timeout (1 bit) and a watchdog counter of width clog2(TIMEOUT+1).
  - The counter clears on entering BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT without i_freeNext:
    - o_timeout pulses one cycle and o_free[grant] pulses (abort).
    - o_driveNext drops, the pointer advances and the FSM goes to RECOVER.
  - i_freeNext in the same cycle as expiry takes precedence: normal completion, no o_timeout.
- Without the macro: no counter and no o_timeout port; BUSY waits indefinitely.

Decomposition:
- Shared package/include cmerge_pkg:
  - state encodings ST_IDLE=2'd0, ST_BUSY=2'd1, ST_RECOVER=2'd2
  - default N/W constants
  - clog2 function
- One natural sub-module: rr_pick.
  - Combinational round-robin selector.
  - Inputs: req[N], ptr. Outputs: valid, idx.
  - Reused by other merge controllers.

Test Plan:
- Single request: i_drive=5'b00100, i_data[14:10]=5'h15 -> o_driveNext=1, o_data=5'h15, o_grant_idx=2 one cycle later; i_freeNext pulse -> o_free=5'b00100 for exactly 1 cycle, o_data=0.
- All five held requesting, i_freeNext pulsed 2 cycles after each o_driveNext rise -> grant order 0,1,2,3,4,0; spacing between driveNext rises = 5 cycles.
- Pointer wrap: pointer=4 after serving 3; i_drive=5'b10001 -> requester 4 granted, then requester 0.
- Stray i_freeNext in IDLE -> o_free stays 0, state unchanged; requester held high through RECOVER -> re-granted only after RECOVER.
- rst asserted mid-BUSY (async, between edges) -> o_driveNext, o_data, o_free go to 0 immediately; after release, pointer=0 and a pending request is granted normally.
- With MERGE_ARB_TIMEOUT_EN, TIMEOUT=8, no i_freeNext -> o_timeout and o_free[grant] pulse 8 cycles after entering BUSY; i_freeNext on cycle 8 -> normal free, o_timeout=0.
